// File: rtl/module_bus_pkg.sv
// Shared definitions for the module-select bus controller: FSM encoding,
// the reserved select value and the timeout counter sizing rule.
package module_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int SEL_RESERVED = 0;

  // Counter must hold values up to TIMEOUT; a disabled timeout still gets 1 bit.
  function automatic int timeout_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/module_bus_timeout.sv
// WAIT-cycle counter for the bus controller; expired_o flags the last cycle
// a module may acknowledge in. Tied low when TIMEOUT is 0.
module module_bus_timeout
  import module_bus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = timeout_cnt_w(TIMEOUT);

  logic [CNT_W-1:0] count;

  assign expired_o = (TIMEOUT != 0) && (count == CNT_W'(TIMEOUT - 1));

  // Holding at the expiry value means the counter can never wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (en_i && !expired_o && (TIMEOUT != 0)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/module_bus_ctrl.sv
// Registered module-select controller: decodes sel_i onto one of N_MODULES
// channels, holds the request until ack or timeout, returns a one-cycle ack/err.
module module_bus_ctrl
  import module_bus_pkg::*;
#(
  parameter int N_MODULES = 4,
  parameter int SEL_W     = 3,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [SEL_W-1:0]              sel_i,
  input  logic [N_MODULES*DATA_W-1:0]   module_data_i,
  input  logic [N_MODULES-1:0]          module_ack_i,
  output logic [N_MODULES-1:0]          module_req_o,
  output logic [N_MODULES-1:0]          module_we_o,
  output logic [DATA_W-1:0]             data_o,
  output logic                          ack_o,
  output logic                          err_o,
  output logic                          busy_o
);

  state_e                           state;
  logic [N_MODULES-1:0]             sel_hot;
  logic [N_MODULES-1:0][DATA_W-1:0] masked;
  logic [DATA_W-1:0]                rd_data;
  logic                             sel_valid;
  logic                             ack_hit;
  logic                             is_write;
  logic                             expired;

  // The registered module_req_o is the latched one-hot channel index: it is
  // nonzero only in WAIT, so acks in IDLE/RESP or on other channels never hit.
  for (genvar j = 0; j < N_MODULES; j++) begin : g_chan
    assign sel_hot[j] = (sel_i == SEL_W'(SEL_RESERVED + j + 1));
    assign masked[j]  = module_req_o[j] ? module_data_i[j*DATA_W +: DATA_W] : '0;
  end

  assign sel_valid = |sel_hot;
  assign ack_hit   = |(module_ack_i & module_req_o);
  assign is_write  = |module_we_o;
  assign busy_o    = (state != IDLE);

  always_comb begin
    // NOTE: default assignment first, so every path drives rd_data and no latch is inferred.
    rd_data = '0;
    for (int j = 0; j < N_MODULES; j++) begin
      rd_data = rd_data | masked[j];
    end
  end

  module_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state == IDLE),
    .en_i      ((state == WAIT) && !ack_hit),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: data_o sits in the async reset with the control flops so a reset never exposes stale read data.
      state        <= IDLE;
      module_req_o <= '0;
      module_we_o  <= '0;
      data_o       <= '0;
      ack_o        <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop updates from pre-edge values.
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_i) begin
            if (sel_valid) begin
              module_req_o <= sel_hot;
              module_we_o  <= we_i ? sel_hot : '0;
              state        <= WAIT;
            end else begin
              err_o <= 1'b1;
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (ack_hit) begin
            if (!is_write) data_o <= rd_data;
            ack_o        <= 1'b1;
            module_req_o <= '0;
            module_we_o  <= '0;
            state        <= RESP;
          end else if (expired) begin
            data_o       <= '0;
            err_o        <= 1'b1;
            module_req_o <= '0;
            module_we_o  <= '0;
            state        <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_bus_ctrl.sv
// Randomised self-checking bench for module_bus_ctrl: three instances
// (N=4/T=16, N=1/T=4, N=7/T=0) against a transaction-level reference model.
module tb_module_bus_ctrl;

  localparam int DW   = 32;
  localparam int NMAX = 7;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        req;
  logic              we;
  logic [2:0]        sel;
  logic [NMAX*DW-1:0] mdata;
  logic [NMAX-1:0]   mack;

  logic [3:0]    req0, we0;
  logic [DW-1:0] d0;
  logic          a0, e0, b0;
  logic [0:0]    req1, we1;
  logic [DW-1:0] d1;
  logic          a1, e1, b1;
  logic [6:0]    req2, we2;
  logic [DW-1:0] d2;
  logic          a2, e2, b2;

  int passed = 0;
  int total  = 0;
  int cur    = 0;
  int n_of[3] = '{4, 1, 7};
  int t_of[3] = '{16, 4, 0};
  logic [DW-1:0] model_data [3];

  // Observed transaction summary and model prediction.
  int            o_resp, o_req_cyc, o_we_cyc, o_bad;
  logic [1:0]    o_kind;
  logic [DW-1:0] o_data;
  int            e_resp, e_req, e_we;
  logic [1:0]    e_kind;
  logic [DW-1:0] e_data;

  logic [6:0]    v_req, v_we;
  logic [DW-1:0] v_data;
  logic          v_ack, v_err, v_busy;

  always #5 clk = ~clk;

  module_bus_ctrl #(.N_MODULES(4), .SEL_W(3), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .we_i(we), .sel_i(sel),
    .module_data_i(mdata[4*DW-1:0]), .module_ack_i(mack[3:0]),
    .module_req_o(req0), .module_we_o(we0), .data_o(d0),
    .ack_o(a0), .err_o(e0), .busy_o(b0));

  module_bus_ctrl #(.N_MODULES(1), .SEL_W(3), .DATA_W(DW), .TIMEOUT(4)) dut_n1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .we_i(we), .sel_i(sel),
    .module_data_i(mdata[DW-1:0]), .module_ack_i(mack[0:0]),
    .module_req_o(req1), .module_we_o(we1), .data_o(d1),
    .ack_o(a1), .err_o(e1), .busy_o(b1));

  module_bus_ctrl #(.N_MODULES(7), .SEL_W(3), .DATA_W(DW), .TIMEOUT(0)) dut_n7 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .we_i(we), .sel_i(sel),
    .module_data_i(mdata), .module_ack_i(mack),
    .module_req_o(req2), .module_we_o(we2), .data_o(d2),
    .ack_o(a2), .err_o(e2), .busy_o(b2));

  always_comb begin
    v_req = {3'b0, req0}; v_we = {3'b0, we0}; v_data = d0;
    v_ack = a0; v_err = e0; v_busy = b0;
    case (cur)
      1: begin
        v_req = {6'b0, req1}; v_we = {6'b0, we1}; v_data = d1;
        v_ack = a1; v_err = e1; v_busy = b1;
      end
      2: begin
        v_req = req2; v_we = we2; v_data = d2;
        v_ack = a2; v_err = e2; v_busy = b2;
      end
      default: ;
    endcase
  end

  // Runs one host transaction on instance `cur`; ack_at = WAIT cycle in which
  // the selected module acks (0 = never). Records what the DUT did.
  task automatic do_txn(input int s, input bit w, input int ack_at, input bit stray,
                        input bit toggle, input bit use_fix, input logic [DW-1:0] fix_val);
    logic [6:0] hot;
    hot = (s >= 1 && s <= n_of[cur]) ? 7'(1 << (s - 1)) : 7'd0;
    for (int j = 0; j < NMAX; j++) mdata[j*DW +: DW] = $urandom;
    if (use_fix && s >= 1) mdata[(s-1)*DW +: DW] = fix_val;
    o_resp = -1; o_kind = 2'b00; o_req_cyc = 0; o_we_cyc = 0; o_bad = 0; o_data = '0;
    @(negedge clk);
    sel = 3'(s); we = w; req[cur] = 1'b1; mack = '0;
    for (int k = 1; k <= 60 && o_resp < 0; k++) begin
      @(negedge clk);
      if (v_ack || v_err) begin
        o_resp = k; o_kind = {v_ack, v_err}; o_data = v_data;
        req[cur] = 1'b0; mack = '0;
        if (v_req != 0 || v_we != 0 || !v_busy) o_bad++;
      end else begin
        if (hot != 0 && v_req == hot) o_req_cyc++;
        else if (v_req != 0) o_bad++;
        if (v_we != 0) begin
          if (w && v_we == hot) o_we_cyc++;
          else o_bad++;
        end
        if (!v_busy) o_bad++;
        mack = stray ? (7'($urandom) & ~hot) : 7'd0;
        if (k == ack_at) mack = mack | hot;
        if (toggle) begin sel = 3'($urandom); we = 1'($urandom); end
      end
    end
    req[cur] = 1'b0;
    @(negedge clk);
    if (v_busy || v_ack || v_err || v_req != 0 || v_data !== o_data) o_bad++;
    mack = 7'($urandom);
    @(negedge clk);
    if (v_busy || v_ack || v_err || v_req != 0) o_bad++;
    mack = '0;
  endtask

  // Reference model: outcome of a transaction from the protocol rules alone.
  task automatic predict(input int s, input bit w, input int ack_at);
    if (s < 1 || s > n_of[cur]) begin
      e_resp = 1; e_kind = 2'b01; e_req = 0; e_we = 0; e_data = model_data[cur];
    end else if (ack_at >= 1 && (t_of[cur] == 0 || ack_at <= t_of[cur])) begin
      e_resp = ack_at + 1; e_kind = 2'b10; e_req = ack_at; e_we = w ? ack_at : 0;
      e_data = w ? model_data[cur] : mdata[(s-1)*DW +: DW];
    end else begin
      e_resp = t_of[cur] + 1; e_kind = 2'b01; e_req = t_of[cur];
      e_we = w ? t_of[cur] : 0; e_data = '0;
    end
    model_data[cur] = e_data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; we = 1'b0; sel = '0; mack = '0; mdata = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cur = d; #1;
      total++;
      if ({v_req, v_we, v_data, v_ack, v_err, v_busy} !== '0)
        $display("FAIL reset_state dut%0d: got req=%b we=%b data=%h ack=%b err=%b busy=%b, want all 0",
                 d, v_req, v_we, v_data, v_ack, v_err, v_busy);
      else passed++;
      model_data[d] = '0;
    end
    cur = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    cur = 0;
    do_txn(2, 1'b0, 1, 1'b0, 1'b0, 1'b1, 32'hCAFE_0001);
    predict(2, 1'b0, 1);
    total++; if (o_req_cyc !== 1) $display("FAIL read_req_cycles: got %0d want 1", o_req_cyc); else passed++;
    total++; if (o_resp !== 2 || o_kind !== 2'b10) $display("FAIL read_latency: got cycle %0d kind %b want cycle 2 kind 10", o_resp, o_kind); else passed++;
    total++; if (o_data !== 32'hCAFE_0001) $display("FAIL read_data: got %h want cafe0001", o_data); else passed++;
    total++; if (o_bad !== 0) $display("FAIL read_protocol: %0d bad cycles, want 0", o_bad); else passed++;
  endtask

  task automatic test_write();
    cur = 0;
    do_txn(4, 1'b1, 3, 1'b0, 1'b0, 1'b0, '0);
    predict(4, 1'b1, 3);
    total++; if (o_we_cyc !== 3 || o_req_cyc !== 3) $display("FAIL write_we_cycles: got we=%0d req=%0d want 3/3", o_we_cyc, o_req_cyc); else passed++;
    total++; if (o_resp !== 4 || o_kind !== 2'b10) $display("FAIL write_ack: got cycle %0d kind %b want cycle 4 kind 10", o_resp, o_kind); else passed++;
    total++; if (o_data !== 32'hCAFE_0001) $display("FAIL write_data_hold: got %h want cafe0001", o_data); else passed++;
    total++; if (o_bad !== 0) $display("FAIL write_protocol: %0d bad cycles, want 0", o_bad); else passed++;
  endtask

  task automatic test_bad_sel();
    int sels[2] = '{0, 5};
    cur = 0;
    for (int i = 0; i < 2; i++) begin
      do_txn(sels[i], 1'($urandom), 1, 1'b1, 1'b0, 1'b0, '0);
      predict(sels[i], 1'b0, 1);
      total++; if (o_resp !== 1 || o_kind !== 2'b01) $display("FAIL bad_sel%0d_err: got cycle %0d kind %b want cycle 1 kind 01", sels[i], o_resp, o_kind); else passed++;
      total++; if (o_req_cyc !== 0 || o_bad !== 0) $display("FAIL bad_sel%0d_untouched: got req_cycles=%0d bad=%0d want 0/0", sels[i], o_req_cyc, o_bad); else passed++;
      total++; if (o_data !== e_data) $display("FAIL bad_sel%0d_data: got %h want %h", sels[i], o_data, e_data); else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] val;
    cur = 0;
    do_txn(1, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0);
    predict(1, 1'b0, 0);
    total++; if (o_resp !== 17 || o_kind !== 2'b01) $display("FAIL timeout_err: got cycle %0d kind %b want cycle 17 kind 01", o_resp, o_kind); else passed++;
    total++; if (o_data !== 32'h0 || o_req_cyc !== 16) $display("FAIL timeout_data: got data=%h req_cycles=%0d want 0/16", o_data, o_req_cyc); else passed++;
    val = $urandom;
    do_txn(1, 1'b0, 16, 1'b0, 1'b0, 1'b1, val);
    predict(1, 1'b0, 16);
    total++; if (o_resp !== 17 || o_kind !== 2'b10) $display("FAIL timeout_last_ack: got cycle %0d kind %b want cycle 17 kind 10", o_resp, o_kind); else passed++;
    total++; if (o_data !== val) $display("FAIL timeout_last_data: got %h want %h", o_data, val); else passed++;
    do_txn(1, 1'b1, 17, 1'b0, 1'b0, 1'b0, '0);
    predict(1, 1'b1, 17);
    total++; if (o_resp !== 17 || o_kind !== 2'b01 || o_data !== 32'h0) $display("FAIL timeout_late_ack: got cycle %0d kind %b data %h want 17/01/0", o_resp, o_kind, o_data); else passed++;
  endtask

  task automatic test_stray();
    bit w;
    int a;
    cur = 0;
    for (int i = 0; i < 8; i++) begin
      w = 1'($urandom);
      a = $urandom_range(1, 12);
      do_txn(1, w, a, 1'b1, 1'b1, 1'b0, '0);
      predict(1, w, a);
      total++;
      if (o_resp !== e_resp || o_kind !== e_kind || o_data !== e_data || o_bad !== 0)
        $display("FAIL stray_%0d: got cycle=%0d kind=%b data=%h bad=%0d want cycle=%0d kind=%b data=%h bad=0",
                 i, o_resp, o_kind, o_data, o_bad, e_resp, e_kind, e_data);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    cur = 0;
    @(negedge clk);
    sel = 3'd3; we = 1'b1; req[0] = 1'b1; mack = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({v_req, v_we, v_data, v_ack, v_err, v_busy} !== '0)
      $display("FAIL reset_mid_async: got req=%b we=%b data=%h ack=%b err=%b busy=%b, want all 0",
               v_req, v_we, v_data, v_ack, v_err, v_busy);
    else passed++;
    req = '0;
    for (int d = 0; d < 3; d++) model_data[d] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_txn(3, 1'b0, 2, 1'b0, 1'b0, 1'b0, '0);
    predict(3, 1'b0, 2);
    total++;
    if (o_resp !== 3 || o_kind !== 2'b10 || o_data !== e_data || o_bad !== 0)
      $display("FAIL reset_mid_recover: got cycle=%0d kind=%b data=%h bad=%0d want cycle=3 kind=10 data=%h bad=0",
               o_resp, o_kind, o_data, o_bad, e_data);
    else passed++;
  endtask

  task automatic test_random(input int which, input int n_txn);
    int  s, a;
    bit  w;
    cur = which;
    for (int i = 0; i < n_txn; i++) begin
      s = $urandom_range(0, 7);
      w = 1'($urandom);
      a = (t_of[cur] == 0) ? $urandom_range(1, 6) : $urandom_range(0, t_of[cur] + 3);
      do_txn(s, w, a, 1'b1, 1'b1, 1'b0, '0);
      predict(s, w, a);
      total++; if (o_resp !== e_resp) $display("FAIL rand_d%0d_%0d_latency: got %0d want %0d", which, i, o_resp, e_resp); else passed++;
      total++; if (o_kind !== e_kind) $display("FAIL rand_d%0d_%0d_kind: got %b want %b", which, i, o_kind, e_kind); else passed++;
      total++; if (o_req_cyc !== e_req || o_we_cyc !== e_we) $display("FAIL rand_d%0d_%0d_cycles: got req=%0d we=%0d want req=%0d we=%0d", which, i, o_req_cyc, o_we_cyc, e_req, e_we); else passed++;
      total++; if (o_data !== e_data) $display("FAIL rand_d%0d_%0d_data: got %h want %h", which, i, o_data, e_data); else passed++;
      total++; if (o_bad !== 0) $display("FAIL rand_d%0d_%0d_protocol: %0d bad cycles, want 0", which, i, o_bad); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_bad_sel();
    test_timeout();
    test_stray();
    test_reset_mid();
    test_random(0, 20);
    test_random(1, 20);
    test_random(2, 20);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
